age_sched: RTL

- Age-ordered issue scheduler with N slots. It holds payloads, tracks readiness, and always offers the oldest ready entry for issue.
- Internally it is the driver and consumer of an age matrix:
  - on allocate, it writes an "older-than" row for the new slot;
  - on issue, it clears that slot's column;
  - it reduces the matrix to a single oldest-ready grant.
- Sits between rename/dispatch (allocate side) and a functional-unit port (issue side).

---
 rtl/age_sched_if.sv | 31 +++
 rtl/age_sched.sv | 114 +++++++++++
 2 files changed

// File: rtl/age_sched_if.sv
// Allocate / wakeup / issue bundle for the age-ordered scheduler.
// The master side is the producer and consumer. It drives the allocate,
// wakeup, flush and issue_ready signals. The slave side is the scheduler.
interface age_sched_if #(
  parameter int ENTRIES = 8,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = $clog2(ENTRIES)
);
  logic               flush;
  logic               alloc_valid;
  logic               alloc_ready;
  logic [DATA_W-1:0]  alloc_data;
  logic               alloc_rdy;
  logic               wake_valid;
  logic [ENTRIES-1:0] wake_sel;
  logic               issue_valid;
  logic               issue_ready;
  logic [DATA_W-1:0]  issue_data;
  logic [IDX_W-1:0]   issue_idx;
  logic [IDX_W:0]     count;

  modport master (
    output flush, alloc_valid, alloc_data, alloc_rdy, wake_valid, wake_sel, issue_ready,
    input  alloc_ready, issue_valid, issue_data, issue_idx, count
  );

  modport slave (
    input  flush, alloc_valid, alloc_data, alloc_rdy, wake_valid, wake_sel, issue_ready,
    output alloc_ready, issue_valid, issue_data, issue_idx, count
  );
endinterface

// File: rtl/age_sched.sv
// Age-ordered issue scheduler.
// Each slot holds a payload and a ready bit. An age matrix records relative
// order: age_q[r][c]=1 means slot c is older than slot r. Among the ready
// slots, the scheduler offers the one that has no older ready slot.
// All outputs come from registered state only.
module age_sched #(
  parameter int ENTRIES = 8,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  age_sched_if.slave  bus
);

  logic [ENTRIES-1:0] valid_q, rdy_q;
  logic [DATA_W-1:0]  data_q [ENTRIES];
  logic [ENTRIES-1:0] age_q  [ENTRIES];

  logic [ENTRIES-1:0] valid_d, rdy_d;
  logic [ENTRIES-1:0] age_d  [ENTRIES];

  logic [ENTRIES-1:0] cand, grant, free_oh;
  logic [ENTRIES-1:0] alloc_mask, issued_mask, wake_mask;
  logic [IDX_W-1:0]   sel_idx, free_idx;
  logic               alloc_ready, issue_valid, alloc_fire, issue_fire;
  logic [IDX_W:0]     cnt;

  // Oldest-ready reduction: a candidate wins when no older slot is also a candidate.
  always_comb begin
    cand  = valid_q & rdy_q;
    grant = '0;
    for (int unsigned e = 0; e < ENTRIES; e++) begin
      grant[e] = cand[e] & ~|(age_q[e] & cand);
    end
  end

  // Encode the one-hot grant into a slot index.
  always_comb begin
    sel_idx = '0;
    for (int unsigned e = 0; e < ENTRIES; e++) begin
      if (grant[e]) sel_idx = IDX_W'(e);
    end
  end

  // Find the lowest-index free slot, as both an index and a one-hot mask.
  always_comb begin
    free_idx = '0;
    free_oh  = '0;
    for (int unsigned e = ENTRIES; e > 0; e--) begin
      if (!valid_q[e-1]) begin
        free_idx = IDX_W'(e - 1);
        free_oh  = '0;
        free_oh[e-1] = 1'b1;
      end
    end
  end

  // Count the occupied slots.
  always_comb begin
    cnt = '0;
    for (int unsigned e = 0; e < ENTRIES; e++) begin
      cnt = cnt + (IDX_W+1)'(valid_q[e]);
    end
  end

  assign alloc_ready = ~&valid_q;
  assign issue_valid = |cand;
  assign alloc_fire  = bus.alloc_valid & alloc_ready;
  assign issue_fire  = issue_valid & bus.issue_ready;
  assign alloc_mask  = alloc_fire ? free_oh : '0;
  assign issued_mask = issue_fire ? grant : '0;
  assign wake_mask   = bus.wake_valid ? (bus.wake_sel & valid_q) : '0;

  assign bus.alloc_ready = alloc_ready;
  assign bus.issue_valid = issue_valid;
  assign bus.issue_idx   = sel_idx;
  assign bus.issue_data  = issue_valid ? data_q[sel_idx] : '0;
  assign bus.count       = cnt;

  // Next-state update for allocate, wakeup and issue in the same cycle.
  // The allocated slot was invalid at cycle start, so wakeup cannot hit it.
  // alloc_rdy alone sets its ready bit. The issue mask is applied last, so
  // a wakeup of the issued slot leaves that slot not ready.
  always_comb begin
    valid_d = (valid_q & ~issued_mask) | alloc_mask;
    rdy_d   = ((rdy_q | wake_mask) & ~issued_mask & ~alloc_mask)
            | (alloc_mask & {ENTRIES{bus.alloc_rdy}});
    for (int unsigned r = 0; r < ENTRIES; r++) begin
      age_d[r] = age_q[r] & ~issued_mask & ~alloc_mask;
      if (issued_mask[r]) age_d[r] = '0;
      if (alloc_mask[r])  age_d[r] = valid_q & ~issued_mask;
    end
  end

  // State registers; reset and flush take priority over every other event.
  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      valid_q <= '0;
      rdy_q   <= '0;
      for (int unsigned r = 0; r < ENTRIES; r++) age_q[r] <= '0;
    end else begin
      valid_q <= valid_d;
      rdy_q   <= rdy_d;
      for (int unsigned r = 0; r < ENTRIES; r++) age_q[r] <= age_d[r];
    end
  end

  // Payload storage. Only valid slots are ever read, so no reset is needed.
  always_ff @(posedge clk) begin
    if (alloc_fire) data_q[free_idx] <= bus.alloc_data;
  end

endmodule
